// File: rtl/wishbus_pkg.sv
// Shared definitions for the stream-to-burst writer: FSM state encoding and
// the burst direction constant seen by the burst engine.
package wishbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_CYC,
    FILL,
    SEQ,
    REL,
    FINISH,
    DONE
  } state_e;

  localparam logic BURST_WE_WRITE = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dat_o presents the oldest word while not empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dat_o   = mem[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= dat_i;
  end

endmodule

// File: rtl/stream_2_burst.sv
// Buffers a 16-bit word stream and hands it to a burst engine as one write
// burst per job, word by word over the seq handshake.
module stream_2_burst
  import wishbus_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] len_i,
  input  logic [15:0] s_dat_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        b_stb_o,
  output logic        b_we_o,
  output logic [15:0] b_len_o,
  output logic [31:0] b_addr_o,
  output logic [15:0] b_dat_o,
  output logic        b_seq_o,
  input  logic        b_cyc_i,
  input  logic        b_seq_i
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [15:0] words_left_q, words_left_d;
  logic [15:0] accept_left_q, accept_left_d;
  logic [15:0] dat_q, dat_d;
  logic        err_q, err_d;

  logic        push, pop, fifo_full, fifo_empty;
  logic [15:0] fifo_dat;

  assign s_ready_o = (state_q != IDLE) & ~fifo_full & (accept_left_q != '0);
  assign push      = s_valid_i & s_ready_o;

  sync_fifo #(
    .WIDTH(16),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .dat_i  (s_dat_i),
    .pop_i  (pop),
    .dat_o  (fifo_dat),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      words_left_q  <= '0;
      accept_left_q <= '0;
      dat_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      words_left_q  <= words_left_d;
      accept_left_q <= accept_left_d;
      dat_q         <= dat_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    words_left_d  = words_left_q;
    accept_left_d = push ? accept_left_q - 1'b1 : accept_left_q;
    dat_d         = dat_q;
    err_d         = 1'b0;
    pop           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          // Only whole 16-bit words can be moved, so odd or empty lengths are refused.
          if ((len_i != '0) && !len_i[0]) begin
            addr_d        = base_addr_i;
            len_d         = len_i;
            words_left_d  = {1'b0, len_i[15:1]};
            accept_left_d = {1'b0, len_i[15:1]};
            state_d       = REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ:      state_d = WAIT_CYC;
      WAIT_CYC: if (b_cyc_i) state_d = FILL;
      FILL: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          dat_d   = fifo_dat;
          state_d = SEQ;
        end
      end
      SEQ: begin
        if (b_seq_i) begin
          words_left_d = words_left_q - 1'b1;
          state_d      = REL;
        end
      end
      REL: begin
        // Wait for the engine to release seq before offering the next word.
        if (!b_seq_i) begin
          if (words_left_q != '0) begin
            state_d = FILL;
          end else begin
            dat_d   = '0;
            state_d = FINISH;
          end
        end
      end
      FINISH:  if (!b_cyc_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign err_o    = err_q;
  assign b_stb_o  = (state_q == REQ);
  assign b_we_o   = BURST_WE_WRITE;
  assign b_len_o  = (state_q == REQ) ? len_q : '0;
  assign b_addr_o = (state_q == REQ) ? addr_q : '0;
  assign b_dat_o  = dat_q;
  assign b_seq_o  = (state_q == SEQ);

endmodule

// File: tb/tb_stream_2_burst.sv
// Directed bench for stream_2_burst: a table of jobs plus hand-written
// sequences for reset mid-burst and restart attempts while busy.
module tb_stream_2_burst;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] len_i = '0;
  logic [15:0] s_dat_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o, busy_o, done_o, err_o, b_stb_o, b_we_o, b_seq_o;
  logic [15:0] b_len_o, b_dat_o;
  logic [31:0] b_addr_o;
  logic        b_cyc_i, b_seq_i;

  stream_2_burst #(.FIFO_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .s_dat_i(s_dat_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .b_stb_o(b_stb_o),
    .b_we_o(b_we_o), .b_len_o(b_len_o), .b_addr_o(b_addr_o), .b_dat_o(b_dat_o),
    .b_seq_o(b_seq_o), .b_cyc_i(b_cyc_i), .b_seq_i(b_seq_i)
  );

  always #5 clk_i = ~clk_i;

  // Burst engine model: raises cyc on the strobe, echoes seq one cycle late
  // (optionally stalled), drops cyc once every word is consumed.
  int stall_req = 0;
  int stall_cnt;
  int remaining;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_cyc_i   <= 1'b0;
      b_seq_i   <= 1'b0;
      stall_cnt <= 0;
      remaining <= 0;
    end else begin
      b_seq_i <= b_seq_o && (stall_cnt == 0);
      if (b_seq_o && stall_cnt > 0) stall_cnt <= stall_cnt - 1;
      if (b_stb_o) begin
        b_cyc_i   <= 1'b1;
        remaining <= int'(b_len_o) / 2;
        stall_cnt <= stall_req;
      end else if (b_seq_o && b_seq_i) begin
        remaining <= remaining - 1;
      end else if (b_cyc_i && remaining == 0 && !b_seq_i && !b_seq_o) begin
        b_cyc_i <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] len;
    logic [31:0] addr;
    int          nwords;
    int          stall;
    logic [15:0] dbase;
    int          exp_err;
    int          exp_stb;
    int          exp_done;
    int          exp_acc;
    int          exp_drop;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [15:0] src [64];
  logic [15:0] got [64];
  int          src_n, acc, got_n, drop_acc;
  int          stb_cnt, done_cnt, err_cnt, we_bad, al_bad;
  logic        pend, busy_seen;
  logic [31:0] stb_addr;
  logic [15:0] stb_len;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; runs the stream source and output monitor at the falling edge.
  task automatic tick();
    @(negedge clk_i);
    if (rst_i) pend = 1'b0;
    if (pend) acc++;
    if (b_stb_o) begin
      stb_cnt++;
      stb_addr = b_addr_o;
      stb_len  = b_len_o;
    end else if (b_addr_o != '0 || b_len_o != '0) begin
      al_bad++;
    end
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (busy_o) busy_seen = 1'b1;
    if ((b_cyc_i || b_stb_o) && b_we_o) we_bad++;
    if (b_seq_o && b_seq_i && got_n < 64) begin
      got[got_n] = b_dat_o;
      got_n++;
    end
    s_valid_i = (acc < src_n);
    s_dat_i   = (acc < 64) ? src[acc] : 16'h0;
    if (busy_o && s_valid_i && !s_ready_o && drop_acc < 0) drop_acc = acc;
    pend = s_valid_i & s_ready_o & ~rst_i;
  endtask

  task automatic clear_stats();
    acc = 0; got_n = 0; drop_acc = -1; pend = 1'b0;
    stb_cnt = 0; done_cnt = 0; err_cnt = 0; we_bad = 0; al_bad = 0;
    busy_seen = 1'b0; stb_addr = '0; stb_len = '0;
  endtask

  task automatic start_job(input logic [15:0] len, input logic [31:0] addr,
                           input int nw, input int stall, input logic [15:0] dbase);
    clear_stats();
    stall_req = stall;
    src_n = nw;
    for (int i = 0; i < 64; i++) src[i] = dbase + 16'(i);
    start_i = 1'b1; len_i = len; base_addr_i = addr;
    tick();
    start_i = 1'b0; len_i = '0; base_addr_i = '0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!((done_cnt > 0 || err_cnt > 0) && !busy_o) && k < 3000) begin
      tick();
      k++;
    end
    chk({tag, "_finished"}, (k < 3000) ? 1 : 0, 1);
    repeat (5) tick();
  endtask

  task automatic check_job(input string tag, input vec_t v);
    chk({tag, "_err"}, err_cnt, v.exp_err);
    chk({tag, "_stb"}, stb_cnt, v.exp_stb);
    chk({tag, "_done"}, done_cnt, v.exp_done);
    chk({tag, "_accepted"}, acc, v.exp_acc);
    chk({tag, "_delivered"}, got_n, v.exp_acc);
    chk({tag, "_busy_seen"}, busy_seen, v.exp_stb);
    chk({tag, "_busy_end"}, busy_o, 0);
    chk({tag, "_we"}, we_bad, 0);
    chk({tag, "_addrlen_idle"}, al_bad, 0);
    chk({tag, "_dat_cleared"}, b_dat_o, 0);
    for (int i = 0; i < got_n && i < v.exp_acc; i++)
      chk($sformatf("%s_word%0d", tag, i), got[i], src[i]);
    if (v.exp_stb != 0) begin
      chk({tag, "_stb_addr"}, stb_addr, v.addr);
      chk({tag, "_stb_len"}, stb_len, v.len);
    end
    if (v.exp_drop >= 0) chk({tag, "_ready_drop_at"}, drop_acc, v.exp_drop);
  endtask

  vec_t vecs [5];
  vec_t v;

  initial begin
    // With the engine stalled, one word sits in b_dat_o and eight fill the FIFO.
    vecs[0] = '{16'd8,  32'h100,  4,  0,  16'h00A1, 0, 1, 1, 4,  -1};
    vecs[1] = '{16'd5,  32'h104,  0,  0,  16'h0000, 1, 0, 0, 0,  -1};
    vecs[2] = '{16'd0,  32'h108,  0,  0,  16'h0000, 1, 0, 0, 0,  -1};
    vecs[3] = '{16'd40, 32'h2000, 20, 20, 16'h3000, 0, 1, 1, 20, 9};
    vecs[4] = '{16'd4,  32'h400,  6,  0,  16'h4000, 0, 1, 1, 2,  2};

    clear_stats();
    src_n = 0;
    repeat (3) tick();
    chk("reset_outputs", |{s_ready_o, busy_o, done_o, err_o, b_stb_o, b_we_o,
                           b_len_o, b_addr_o, b_dat_o, b_seq_o}, 0);
    chk("reset_busy", busy_o, 0);
    rst_i = 1'b0;
    repeat (2) tick();

    for (int n = 0; n < 5; n++) begin
      v = vecs[n];
      start_job(v.len, v.addr, v.nwords, v.stall, v.dbase);
      wait_idle($sformatf("vec%0d", n));
      check_job($sformatf("vec%0d", n), v);
    end

    // Restart attempts while busy must be ignored silently.
    v = '{16'd8, 32'h300, 4, 0, 16'h5000, 0, 1, 1, 4, -1};
    start_job(v.len, v.addr, v.nwords, v.stall, v.dbase);
    repeat (2) tick();
    start_i = 1'b1; len_i = 16'd5; base_addr_i = 32'h999;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    start_i = 1'b1; len_i = 16'd6; base_addr_i = 32'h777;
    tick();
    start_i = 1'b0; len_i = '0; base_addr_i = '0;
    wait_idle("busy_start");
    check_job("busy_start", v);

    // Asynchronous reset while a word is being presented.
    start_job(16'd8, 32'h500, 4, 50, 16'h00C0);
    for (int k = 0; k < 200 && !b_seq_o; k++) tick();
    chk("rst_in_seq_reached", b_seq_o, 1);
    chk("rst_in_seq_dat", b_dat_o, 16'h00C0);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_outputs", |{s_ready_o, busy_o, done_o, err_o, b_stb_o, b_we_o,
                               b_len_o, b_addr_o, b_dat_o, b_seq_o}, 0);
    chk("rst_async_seq", b_seq_o, 0);
    repeat (3) tick();
    rst_i = 1'b0;
    src_n = 0;
    repeat (10) tick();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle", busy_o, 0);

    v = '{16'd2, 32'h600, 1, 0, 16'h6000, 0, 1, 1, 1, -1};
    start_job(v.len, v.addr, v.nwords, v.stall, v.dbase);
    wait_idle("post_rst");
    check_job("post_rst", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
